// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key-schedule slice.
//   - FSM state encoding for aes_key_expand
//   - key, word and RCON widths, default round count
//   - RotWord helper
package aes_pkg;

  localparam int unsigned AES_KEY_W  = 128;
  localparam int unsigned AES_WORD_W = 32;
  localparam int unsigned RCON_W     = 8;
  localparam int unsigned NR_DEFAULT = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EMIT,
    ST_REQ,
    ST_WAIT,
    ST_CALC,
    ST_ERR
  } ks_state_t;

  // Cyclic left rotation by one byte: {a0,a1,a2,a3} -> {a1,a2,a3,a0}
  function automatic logic [AES_WORD_W-1:0] rot_word(input logic [AES_WORD_W-1:0] w);
    return {w[AES_WORD_W-9:0], w[AES_WORD_W-1:AES_WORD_W-8]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// FIPS-197 S-box, purely combinational.
//   a : input byte
//   s : substituted byte
// Computed as the GF(2^8) multiplicative inverse (a^254, with 0 -> 0)
// followed by the FIPS-197 affine transform, rather than a lookup table.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = '0;
    xx = x;
    for (int unsigned i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  always_comb begin
    // a^254 = a^2 * a^4 * ... * a^128
    sq  = gf_mul(a, a);
    inv = sq;
    for (int unsigned i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    s = inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key-schedule engine.
// Captures a 128-bit cipher key on start and emits round keys 0..NR one at a
// time over a valid/ready handshake. For each round after 0 it reads one RCON
// byte from an external constant memory (rd_en pulse, wait for done), then
// applies RotWord/SubWord/RCON and the word-chain XORs.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, key_in     begin expansion of key_in (accepted in IDLE or ERR)
//   rk_out, rk_idx    current round key and its index
//   rk_valid/rk_ready round-key handshake
//   busy, done, err   status: running, finished pulse, sticky RCON timeout
//   rcon_rd_en/addr   RCON memory read request
//   rcon_data/done    RCON memory read response
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned NR        = NR_DEFAULT,
  parameter logic [7:0]  RCON_BASE = 8'h00,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AES_KEY_W-1:0]  key_in,
  output logic [AES_KEY_W-1:0]  rk_out,
  output logic [3:0]            rk_idx,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rcon_rd_en,
  output logic [7:0]            rcon_addr,
  input  logic [RCON_W-1:0]     rcon_data,
  input  logic                  rcon_done
);

  localparam logic [3:0] LAST_IDX = 4'(NR);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  ks_state_t state_q, state_d;

  logic [AES_KEY_W-1:0]  key_q;
  logic [3:0]            idx_q;
  logic [7:0]            cnt_q;
  logic [7:0]            addr_q;
  logic [RCON_W-1:0]     rcon_q;
  logic                  busy_q, done_q, err_q;

  logic accept, finish, to_req, clr_cnt, tick, rcon_take, timeout, calc;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    finish    = 1'b0;
    to_req    = 1'b0;
    clr_cnt   = 1'b0;
    tick      = 1'b0;
    rcon_take = 1'b0;
    timeout   = 1'b0;
    calc      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rk_ready) begin
          if (idx_q == LAST_IDX) begin
            finish  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            to_req  = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        clr_cnt = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rcon_done) begin
          rcon_take = 1'b1;
          state_d   = ST_CALC;
        end else if (cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = ST_ERR;
        end else begin
          tick = 1'b1;
        end
      end
      ST_CALC: begin
        calc    = 1'b1;
        state_d = ST_EMIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------- next key
  logic [AES_WORD_W-1:0] w0, w1, w2, w3, rot, sub, temp;
  logic [AES_WORD_W-1:0] n0, n1, n2, n3;

  assign w0  = key_q[127:96];
  assign w1  = key_q[95:64];
  assign w2  = key_q[63:32];
  assign w3  = key_q[31:0];
  assign rot = rot_word(w3);

  aes_sbox u_sbox0 (.a(rot[31:24]), .s(sub[31:24]));
  aes_sbox u_sbox1 (.a(rot[23:16]), .s(sub[23:16]));
  aes_sbox u_sbox2 (.a(rot[15:8]),  .s(sub[15:8]));
  aes_sbox u_sbox3 (.a(rot[7:0]),   .s(sub[7:0]));

  assign temp = sub ^ {rcon_q, 24'h0};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  // --------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      addr_q <= '0;
      rcon_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        key_q  <= key_in;
        idx_q  <= '0;
        err_q  <= 1'b0;
        busy_q <= 1'b1;
      end
      if (finish) busy_q <= 1'b0;
      // Address is registered so it is valid during REQ and holds through WAIT
      if (to_req) addr_q <= RCON_BASE + {4'b0, idx_q};
      if (clr_cnt) cnt_q <= '0;
      if (tick)    cnt_q <= cnt_q + 8'd1;
      if (timeout) begin
        err_q  <= 1'b1;
        busy_q <= 1'b0;
      end
      if (rcon_take) rcon_q <= rcon_data;
      if (calc) begin
        key_q <= {n0, n1, n2, n3};
        idx_q <= idx_q + 4'd1;
      end
    end
  end

  // ----------------------------------------------------------- outputs
  assign rk_valid   = (state_q == ST_EMIT);
  assign rk_out     = rk_valid ? key_q : '0;
  assign rk_idx     = rk_valid ? idx_q : '0;
  assign rcon_rd_en = (state_q == ST_REQ);
  assign rcon_addr  = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 A.1 schedule, backpressure,
// RCON address sequence, ignored restart, RCON timeout and async reset.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy, done, err;
  logic         rcon_rd_en;
  logic [7:0]   rcon_addr;
  logic [7:0]   rcon_data = 8'h00;
  logic         rcon_done = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } vec_t;

  vec_t       exp_tab [11];
  logic [7:0] mem [256];
  bit         mem_dead = 1'b0;
  logic [7:0] rd_q [$];
  int         rd_wide = 0;
  logic       rd_prev = 1'b0;

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_expand #(.NR(10), .RCON_BASE(8'h00), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .rk_out(rk_out), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .busy(busy), .done(done), .err(err),
    .rcon_rd_en(rcon_rd_en), .rcon_addr(rcon_addr),
    .rcon_data(rcon_data), .rcon_done(rcon_done)
  );

  always #5 clk = ~clk;

  // RCON memory: one-cycle done pulse in the cycle after rd_en
  always @(posedge clk) begin
    rcon_done <= 1'b0;
    if (rcon_rd_en && !mem_dead) begin
      rcon_done <= 1'b1;
      rcon_data <= mem[rcon_addr];
    end
  end

  // Read-request monitor
  always @(posedge clk) begin
    if (rcon_rd_en) begin
      rd_q.push_back(rcon_addr);
      if (rd_prev) rd_wide++;
    end
    rd_prev <= rcon_rd_en;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Full schedule with rk_ready high except for an optional stall at one index;
  // optionally re-asserts start (with another key) while round restart_at is shown.
  task automatic run_sched(input string tag, input logic [127:0] key, input int stall_at,
                           input int stall_len, input int restart_at, input int exp_done);
    int edges, nxt, stalled, base, wide0;
    bit seen_done, restarted;
    base  = rd_q.size();
    wide0 = rd_wide;
    @(negedge clk);
    key_in = key; start = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; key_in = ~key;
    edges = 0; nxt = 0; stalled = 0; seen_done = 1'b0; restarted = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_err_start"}, err, 0);
    while (!seen_done && edges < 200) begin
      if (done) begin
        seen_done = 1'b1;
        check({tag, "_done_latency"}, edges, exp_done);
        check({tag, "_keys_seen"}, nxt, 11);
        check({tag, "_busy_at_done"}, busy, 0);
      end else if (rk_valid) begin
        if (nxt <= 10) begin
          check($sformatf("%s_idx%0d", tag, nxt), rk_idx, exp_tab[nxt].idx);
          check($sformatf("%s_key%0d", tag, nxt), rk_out, exp_tab[nxt].key);
        end else begin
          check({tag, "_extra_key"}, rk_idx, 0);
        end
        if (nxt == restart_at && !restarted) begin
          start = 1'b1; key_in = {key[63:0], key[127:64]} ^ 128'h5a;
          restarted = 1'b1;
        end
        if (nxt == stall_at && stalled < stall_len) begin
          rk_ready = 1'b0;
          stalled++;
          check($sformatf("%s_stall_rd%0d", tag, stalled), rcon_rd_en, 0);
        end else begin
          rk_ready = 1'b1;
          nxt++;
        end
      end
      @(negedge clk);
      start = 1'b0;
      edges++;
    end
    rk_ready = 1'b1;
    check({tag, "_done_seen"}, seen_done, 1);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_valid"}, rk_valid, 0);
    check({tag, "_reads"}, rd_q.size() - base, 10);
    for (int i = 0; i < 10; i++)
      if (base + i < rd_q.size())
        check($sformatf("%s_addr%0d", tag, i), rd_q[base + i], i);
    check({tag, "_rd_single"}, rd_wide - wide0, 0);
  endtask

  initial begin
    logic [7:0] rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                            8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    int  edges, base;
    bit  found;

    exp_tab[0]  = '{4'd0,  KEY_A1};
    exp_tab[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    exp_tab[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    exp_tab[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    exp_tab[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    exp_tab[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    exp_tab[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    exp_tab[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    exp_tab[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    exp_tab[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    exp_tab[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 10; i++) mem[i] = rc[i];

    rst = 1'b0; start = 1'b0; rk_ready = 1'b1; key_in = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", rk_valid, 0);
    check("rst_rk_out", rk_out, 0);
    check("rst_rk_idx", rk_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd_en", rcon_rd_en, 0);
    check("rst_addr", rcon_addr, 0);
    rst = 1'b1;

    run_sched("a1", KEY_A1, -1, 0, -1, 41);
    run_sched("bp", KEY_A1, 3, 5, -1, 46);
    run_sched("rs", KEY_A1, -1, 0, 4, 41);

    // RCON timeout
    mem_dead = 1'b1;
    base = rd_q.size();
    @(negedge clk); key_in = ~KEY_A1; start = 1'b1; rk_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    edges = 0;
    while (!err && edges < 100) begin
      if (edges == 17) begin
        check("to_busy_before", busy, 1);
        check("to_err_before", err, 0);
      end
      @(negedge clk);
      edges++;
    end
    check("to_err_edges", edges, 18);
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("to_err_sticky", err, 1);
    check("to_valid_idle", rk_valid, 0);
    check("to_rd_idle", rcon_rd_en, 0);
    check("to_reads", rd_q.size() - base, 1);
    mem_dead = 1'b0;
    run_sched("to_rerun", KEY_A1, -1, 0, -1, 41);

    // Async reset while in CALC for round 3
    @(negedge clk); key_in = KEY_A1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (rcon_done && rcon_addr == 8'd2) found = 1'b1;
      else @(negedge clk);
    end
    check("ar_reach_wait", found, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("ar_valid", rk_valid, 0);
    check("ar_rk_out", rk_out, 0);
    check("ar_rk_idx", rk_idx, 0);
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_err", err, 0);
    check("ar_rd_en", rcon_rd_en, 0);
    check("ar_addr", rcon_addr, 0);
    repeat (3) begin
      @(negedge clk);
      check("ar_no_done", done, 0);
    end
    rst = 1'b1;
    run_sched("ar_rerun", KEY_A1, -1, 0, -1, 41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
